mmio_timer: RTL and testbench
=============================

# mmio_timer

Memory-mapped timer peripheral that acts as a responder on the processor's data-memory port, the same `we`/`a`/`wd`/`rd` interface that the data memory serves. It decodes a fixed 32-byte window and provides a prescaled 32-bit counter, a compare match, overflow detection and a level interrupt. In `top` it sits beside `dmem`:
- `dmem` write enable is gated with `!hit`.
- Processor `readdata` is `hit ? timer rd : dmem rd`.

## Interface
- `BASE`, 32'hFFFF_FF00, window base address; must be 32-byte aligned.
- `PRESC_W`, 16, prescaler width in bits.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; takes effect on the rising edge of `clk`.
- `we`  in  1  store strobe from the processor, qualified by `hit`.
- `a`  in  32  byte address (processor `aluout`).
- `wd`  in  32  store data.
- `rd`  out  32  load data; combinational from `a`; 0 when `!hit`.
- `hit`  out  1  combinational; `a[31:5] == BASE[31:5]`.
- `irq`  out  1  interrupt level; equals `IE & (MATCH | OVF)` from registered state.

## Operation
- Register map, word offset `a[4:2]`:
  - 0 CTRL: bit0 EN, bit1 AR (auto-reload), bit2 IE.
  - 1 PRESCALE: `[PRESC_W-1:0]`.
  - 2 COUNT: `[31:0]`, read/write.
  - 3 COMPARE: `[31:0]`.
  - 4 STATUS: bit0 MATCH, bit1 OVF; write-1-to-clear.
  - 5–7 reserved: read 0, writes ignored.
- Unused register bits read 0. `a[1:0]` is ignored.
- A write occurs on the edge where `we & hit`.
- Reset values: all registers 0; internal prescale count `pcnt` = 0. Outputs after reset: `irq` = 0; `rd` = 0 for every in-window address.
- Prescaler:
  - When EN = 1: if `pcnt == PRESCALE`, then `pcnt ← 0` and `tick` = 1. Otherwise `pcnt ← pcnt + 1`.
  - When EN = 0: `pcnt` holds and no tick is produced.
  - Any write to CTRL or PRESCALE forces `pcnt ← 0`.
- On `tick`, evaluated on the pre-update COUNT:
  - If `COUNT == COMPARE`: MATCH ← 1. Then COUNT ← 0 if AR = 1, otherwise COUNT ← COUNT + 1.
  - Else if `COUNT == 32'hFFFF_FFFF`: COUNT ← 0 and OVF ← 1.
  - Else: COUNT ← COUNT + 1.
  - If COMPARE = 32'hFFFF_FFFF and AR = 0, a single tick sets both MATCH and OVF.
- Simultaneous events:
  - A software write to COUNT overrides the tick update in the same cycle.
  - A hardware flag set overrides a same-cycle W1C clear, so the flag stays 1.
  - A STATUS write with 0 bits leaves those flags unchanged.
  - A tick in the same cycle as a CTRL write uses the old CTRL values.

## Timing
- Reads are zero-latency (combinational), so a load completes in the single-cycle processor's cycle.
- A write is visible on `rd` the cycle after its edge.
- EN is written at edge E with PRESCALE = P:
  - The first tick updates COUNT at edge E+P+1.
  - Subsequent ticks occur every P+1 cycles.
- With AR = 1, the match period is (COMPARE + 1) × (P + 1) cycles.
- `irq` rises the cycle after the edge that sets a flag. It falls the cycle after the W1C edge, unless the flag is re-set on that same edge.
- A `reset` mid-count returns all state to reset values on that edge; `irq` = 0 in the following cycle.
- There is no handshake and no back-pressure. The block never stalls the processor.

## Structure
- Package `timer_pkg`:
  - Register offset constants: `TMR_CTRL`, `TMR_PRESC`, `TMR_COUNT`, `TMR_CMP`, `TMR_STAT`.
  - CTRL/STATUS bit index constants.
  - `BASE` default.
- Sub-module `tick_gen`:
  - Ports: `clk`, `reset`, `en`, `clr`, `presc[PRESC_W-1:0]` → `tick`.
  - Owns `pcnt`.
- The top level holds the register file, counter/compare logic, read mux and `irq`.

## Test plan
- Reset, then read all 8 offsets at `BASE` → all return 0. `irq` = 0. `hit` = 0 for `a` = 32'h0000_0040.
- PRESCALE = 0, COMPARE = 3, CTRL = 3'b111 → COUNT sequence 1,2,3,0 on successive edges. MATCH and `irq` are 1 one cycle after COUNT wraps 3→0. Period is 4 cycles.
- PRESCALE = 4, CTRL = 1 → COUNT increments exactly every 5 cycles. A PRESCALE rewrite mid-interval restarts the 5-cycle spacing from the write edge.
- COUNT = 32'hFFFF_FFFE, COMPARE = 0, PRESCALE = 0, EN = 1 → COUNT goes FFFF_FFFF, then 0 with OVF = 1, then 1 with MATCH = 1. MATCH is set on the tick where the pre-update COUNT is 0.
- A STATUS write of 1 on the same edge that a match sets MATCH → MATCH remains 1. A STATUS write of 1 on a later edge → MATCH = 0 and `irq` = 0 next cycle.
- `reset` asserted while COUNT = 7 and `irq` = 1 → next cycle COUNT = 0, CTRL = 0, `irq` = 0. No ticks occur until EN is rewritten.

Source files
------------

// File: rtl/mmio_timer_pkg.sv
// Shared constants for the memory-mapped timer: register offsets, bit indices, default base.
package timer_pkg;

    // Default window base; must be 32-byte aligned.
    localparam logic [31:0] TMR_BASE = 32'hFFFF_FF00;

    // Word offsets within the window (a[4:2]).
    localparam logic [2:0] TMR_CTRL  = 3'd0;
    localparam logic [2:0] TMR_PRESC = 3'd1;
    localparam logic [2:0] TMR_COUNT = 3'd2;
    localparam logic [2:0] TMR_CMP   = 3'd3;
    localparam logic [2:0] TMR_STAT  = 3'd4;

    // CTRL bit indices.
    localparam int unsigned CTRL_EN = 0;
    localparam int unsigned CTRL_AR = 1;
    localparam int unsigned CTRL_IE = 2;

    // STATUS bit indices.
    localparam int unsigned STAT_MATCH = 0;
    localparam int unsigned STAT_OVF   = 1;

    // True when addr falls inside the 32-byte window starting at base.
    function automatic logic in_window(input logic [31:0] addr, input logic [31:0] base);
        return addr[31:5] == base[31:5];
    endfunction

endpackage

// File: rtl/mmio_timer_if.sv
// Data-memory style bus shared by the processor and the timer responder.
interface mmio_timer_if;
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        hit;

    modport master (output we, output a, output wd, input rd, input hit);
    modport slave  (input we, input a, input wd, output rd, output hit);
endinterface

// File: rtl/mmio_timer_tick_gen.sv
// Prescaler: emits a one-cycle tick every (presc + 1) enabled cycles.
module tick_gen #(
    parameter int unsigned PRESC_W = 16
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               en_i,
    input  logic               clr_i,
    input  logic [PRESC_W-1:0] presc_i,
    output logic               tick_o
);

    logic [PRESC_W-1:0] pcnt_q, pcnt_d;

    // Tick uses the current (pre-write) enable and prescale values.
    assign tick_o = en_i && (pcnt_q == presc_i);

    // Next prescale count; a CTRL/PRESCALE write restarts the interval.
    always_comb begin
        pcnt_d = pcnt_q;
        if (en_i) begin
            pcnt_d = tick_o ? '0 : pcnt_q + PRESC_W'(1);
        end
        if (clr_i) begin
            pcnt_d = '0;
        end
    end

    // Prescale count register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped timer: register file, prescaled counter with compare/overflow, level irq.
module mmio_timer
    import timer_pkg::*;
#(
    parameter logic [31:0] BASE    = TMR_BASE,
    parameter int unsigned PRESC_W = 16
) (
    input  logic         clk_i,
    input  logic         reset_i,
    mmio_timer_if.slave  bus,
    output logic         irq_o
);

    logic [2:0]         ctrl_q, ctrl_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [31:0]        count_q, count_d;
    logic [31:0]        cmp_q, cmp_d;
    logic [1:0]         stat_q, stat_d;

    logic       hit;
    logic       wr;
    logic [2:0] off;
    logic       tick;
    logic       unused_addr;

    assign hit         = in_window(bus.a, BASE);
    assign bus.hit     = hit;
    assign wr          = bus.we & hit;
    assign off         = bus.a[4:2];
    assign unused_addr = ^bus.a[1:0];

    tick_gen #(
        .PRESC_W (PRESC_W)
    ) u_tick_gen (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (ctrl_q[CTRL_EN]),
        .clr_i   (wr && (off == TMR_CTRL || off == TMR_PRESC)),
        .presc_i (presc_q),
        .tick_o  (tick)
    );

    // Next-state: counter/flag update on tick, then software writes on top.
    always_comb begin
        logic [1:0] set;
        logic [1:0] clr;

        ctrl_d  = ctrl_q;
        presc_d = presc_q;
        count_d = count_q;
        cmp_d   = cmp_q;
        set     = '0;
        clr     = '0;

        if (tick) begin
            if (count_q == cmp_q) begin
                set[STAT_MATCH] = 1'b1;
                if (ctrl_q[CTRL_AR]) begin
                    count_d = '0;
                end else begin
                    count_d       = count_q + 32'd1;
                    // Compare at all-ones without reload also wraps.
                    set[STAT_OVF] = (count_q == 32'hFFFF_FFFF);
                end
            end else if (count_q == 32'hFFFF_FFFF) begin
                count_d       = '0;
                set[STAT_OVF] = 1'b1;
            end else begin
                count_d = count_q + 32'd1;
            end
        end

        if (wr) begin
            case (off)
                TMR_CTRL:  ctrl_d  = bus.wd[2:0];
                TMR_PRESC: presc_d = bus.wd[PRESC_W-1:0];
                TMR_COUNT: count_d = bus.wd;
                TMR_CMP:   cmp_d   = bus.wd;
                TMR_STAT:  clr     = bus.wd[1:0];
                default:   ;
            endcase
        end

        // Hardware set wins over a same-cycle write-1-to-clear.
        stat_d = (stat_q & ~clr) | set;
    end

    // Register file with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ctrl_q  <= '0;
            presc_q <= '0;
            count_q <= '0;
            cmp_q   <= '0;
            stat_q  <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            presc_q <= presc_d;
            count_q <= count_d;
            cmp_q   <= cmp_d;
            stat_q  <= stat_d;
        end
    end

    // Zero-latency read mux; 0 outside the window and for reserved offsets.
    always_comb begin
        bus.rd = '0;
        if (hit) begin
            case (off)
                TMR_CTRL:  bus.rd = {29'd0, ctrl_q};
                TMR_PRESC: bus.rd = 32'(presc_q);
                TMR_COUNT: bus.rd = count_q;
                TMR_CMP:   bus.rd = cmp_q;
                TMR_STAT:  bus.rd = {30'd0, stat_q};
                default:   bus.rd = '0;
            endcase
        end
    end

    assign irq_o = ctrl_q[CTRL_IE] & (|stat_q);

endmodule

// File: tb/tb_mmio_timer.sv
// Self-checking bench for mmio_timer: directed scenarios plus randomized traffic vs a model.
module tb_mmio_timer;
    import timer_pkg::*;

    localparam logic [31:0] BASE = 32'hFFFF_FF00;
    localparam int unsigned PW   = 16;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic irq;

    mmio_timer_if bus ();

    mmio_timer #(
        .BASE    (BASE),
        .PRESC_W (PW)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus.slave),
        .irq_o   (irq)
    );

    always #10 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state, stepped once per rising edge.
    logic [2:0]    m_ctrl  = '0;
    logic [PW-1:0] m_presc = '0;
    logic [PW-1:0] m_pcnt  = '0;
    logic [31:0]   m_count = '0;
    logic [31:0]   m_cmp   = '0;
    logic [1:0]    m_stat  = '0;

    task automatic model_step();
        bit            wr;
        int            o;
        bit            tick;
        logic [31:0]   nc;
        logic [PW-1:0] np;
        logic [1:0]    set;
        logic [1:0]    clr;
        if (reset) begin
            m_ctrl = '0; m_presc = '0; m_pcnt = '0; m_count = '0; m_cmp = '0; m_stat = '0;
            return;
        end
        wr   = bus.we && (bus.a[31:5] == BASE[31:5]);
        o    = int'(bus.a[4:2]);
        tick = m_ctrl[0] && (m_pcnt == m_presc);
        np   = m_pcnt;
        if (m_ctrl[0]) np = tick ? '0 : m_pcnt + 1'b1;
        if (wr && o <= 1) np = '0;
        nc  = m_count;
        set = 2'b00;
        clr = 2'b00;
        if (tick) begin
            if (m_count == m_cmp) begin
                set[0] = 1'b1;
                if (m_ctrl[1]) nc = 0;
                else begin
                    nc = m_count + 1;
                    if (m_count == 32'hFFFF_FFFF) set[1] = 1'b1;
                end
            end else if (m_count == 32'hFFFF_FFFF) begin
                nc = 0; set[1] = 1'b1;
            end else begin
                nc = m_count + 1;
            end
        end
        if (wr) begin
            case (o)
                0: m_ctrl  = bus.wd[2:0];
                1: m_presc = bus.wd[PW-1:0];
                2: nc      = bus.wd;
                3: m_cmp   = bus.wd;
                4: clr     = bus.wd[1:0];
                default: ;
            endcase
        end
        m_pcnt  = np;
        m_count = nc;
        m_stat  = (m_stat & ~clr) | set;
    endtask

    function automatic logic [31:0] m_read(input int o);
        case (o)
            0: return {29'd0, m_ctrl};
            1: return 32'(m_presc);
            2: return m_count;
            3: return m_cmp;
            4: return {30'd0, m_stat};
            default: return 32'd0;
        endcase
    endfunction

    // Advance one rising edge, keeping the model in lockstep; returns 1 time unit after it.
    task automatic clk_edge();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) clk_edge();
    endtask

    task automatic bus_write(input logic [2:0] o, input logic [31:0] d);
        bus.we = 1'b1;
        bus.a  = BASE + (32'(o) << 2);
        bus.wd = d;
        clk_edge();
        bus.we = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] o, output logic [31:0] d);
        bus.we = 1'b0;
        bus.a  = BASE + (32'(o) << 2);
        #1;
        d = bus.rd;
    endtask

    // Stop the counter and clear state between scenarios.
    task automatic quiesce();
        bus_write(TMR_CTRL, 32'd0);
        bus_write(TMR_STAT, 32'd3);
        bus_write(TMR_COUNT, 32'd0);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus_read(3'(i), d);
            n_checks++;
            if (d !== 32'd0) $display("FAIL reset_rd off=%0d got=%h exp=0", i, d);
            else n_pass++;
        end
        n_checks++;
        if (irq !== 1'b0) $display("FAIL reset_irq got=%b exp=0", irq);
        else n_pass++;
        bus.a = 32'h0000_0040;
        #1;
        n_checks++;
        if (bus.hit !== 1'b0 || bus.rd !== 32'd0)
            $display("FAIL miss_hit got hit=%b rd=%h exp hit=0 rd=0", bus.hit, bus.rd);
        else n_pass++;
        bus.a = BASE + 32'd3;
        #1;
        n_checks++;
        if (bus.hit !== 1'b1) $display("FAIL base_hit got=%b exp=1", bus.hit);
        else n_pass++;
    endtask

    task automatic test_compare_autoreload();
        logic [31:0] d;
        logic [31:0] exp_cnt [4] = '{32'd1, 32'd2, 32'd3, 32'd0};
        quiesce();
        bus_write(TMR_PRESC, 32'd0);
        bus_write(TMR_CMP, 32'd3);
        bus_write(TMR_CTRL, 32'd7);
        for (int i = 0; i < 4; i++) begin
            clk_edge();
            bus_read(TMR_COUNT, d);
            n_checks++;
            if (d !== exp_cnt[i]) $display("FAIL ar_count step=%0d got=%h exp=%h", i, d, exp_cnt[i]);
            else n_pass++;
            bus_read(TMR_STAT, d);
            n_checks++;
            if (d !== ((i == 3) ? 32'd1 : 32'd0) || irq !== (i == 3))
                $display("FAIL ar_match step=%0d got stat=%h irq=%b exp=%0d", i, d, irq, i == 3);
            else n_pass++;
        end
        idle(3);
        bus_read(TMR_COUNT, d);
        n_checks++;
        if (d !== 32'd3) $display("FAIL ar_period3 got=%h exp=3", d);
        else n_pass++;
        idle(1);
        bus_read(TMR_COUNT, d);
        n_checks++;
        if (d !== 32'd0) $display("FAIL ar_period4 got=%h exp=0", d);
        else n_pass++;
    endtask

    task automatic test_prescale();
        logic [31:0] d;
        logic [31:0] exp_seq [6] = '{32'd0, 32'd1, 32'd1, 32'd2, 32'd2, 32'd3};
        int          gaps    [6] = '{4, 1, 4, 1, 4, 1};
        quiesce();
        bus_write(TMR_PRESC, 32'd4);
        bus_write(TMR_CTRL, 32'd1);
        for (int i = 0; i < 6; i++) begin
            // Rewrite PRESCALE two edges into the third interval.
            if (i == 4) begin
                idle(1);
                bus_write(TMR_PRESC, 32'd4);
            end
            idle(gaps[i]);
            bus_read(TMR_COUNT, d);
            n_checks++;
            if (d !== exp_seq[i]) $display("FAIL presc_count step=%0d got=%h exp=%h", i, d, exp_seq[i]);
            else n_pass++;
        end
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        logic [31:0] exp_cnt  [3] = '{32'hFFFF_FFFF, 32'd0, 32'd1};
        logic [31:0] exp_stat [3] = '{32'd0, 32'd2, 32'd3};
        quiesce();
        bus_write(TMR_PRESC, 32'd0);
        bus_write(TMR_CMP, 32'd0);
        bus_write(TMR_COUNT, 32'hFFFF_FFFE);
        bus_write(TMR_CTRL, 32'd1);
        for (int i = 0; i < 3; i++) begin
            clk_edge();
            bus_read(TMR_COUNT, d);
            n_checks++;
            if (d !== exp_cnt[i]) $display("FAIL ovf_count step=%0d got=%h exp=%h", i, d, exp_cnt[i]);
            else n_pass++;
            bus_read(TMR_STAT, d);
            n_checks++;
            if (d !== exp_stat[i] || irq !== 1'b0)
                $display("FAIL ovf_stat step=%0d got=%h irq=%b exp=%h irq=0", i, d, irq, exp_stat[i]);
            else n_pass++;
        end
        // Compare at all-ones without reload: one tick sets both flags.
        quiesce();
        bus_write(TMR_CMP, 32'hFFFF_FFFF);
        bus_write(TMR_COUNT, 32'hFFFF_FFFF);
        bus_write(TMR_CTRL, 32'd1);
        clk_edge();
        bus_read(TMR_STAT, d);
        n_checks++;
        if (d !== 32'd3) $display("FAIL cmp_max_stat got=%h exp=3", d);
        else n_pass++;
        bus_read(TMR_COUNT, d);
        n_checks++;
        if (d !== 32'd0) $display("FAIL cmp_max_count got=%h exp=0", d);
        else n_pass++;
    endtask

    task automatic test_w1c();
        logic [31:0] d;
        quiesce();
        bus_write(TMR_PRESC, 32'd0);
        bus_write(TMR_CMP, 32'd3);
        bus_write(TMR_CTRL, 32'd7);
        idle(3);
        // Clear lands on the edge where the match fires.
        bus_write(TMR_STAT, 32'd1);
        bus_read(TMR_STAT, d);
        n_checks++;
        if (d !== 32'd1 || irq !== 1'b1) $display("FAIL w1c_race got=%h irq=%b exp=1 irq=1", d, irq);
        else n_pass++;
        bus_write(TMR_STAT, 32'd1);
        bus_read(TMR_STAT, d);
        n_checks++;
        if (d !== 32'd0 || irq !== 1'b0) $display("FAIL w1c_clear got=%h irq=%b exp=0 irq=0", d, irq);
        else n_pass++;
        bus_read(TMR_COUNT, d);
        n_checks++;
        if (d !== 32'd1) $display("FAIL w1c_count got=%h exp=1", d);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        quiesce();
        bus_write(TMR_PRESC, 32'd0);
        bus_write(TMR_CMP, 32'd2);
        bus_write(TMR_CTRL, 32'd5);
        idle(7);
        bus_read(TMR_COUNT, d);
        n_checks++;
        if (d !== 32'd7 || irq !== 1'b1) $display("FAIL rstmid_pre got=%h irq=%b exp=7 irq=1", d, irq);
        else n_pass++;
        reset = 1'b1;
        clk_edge();
        reset = 1'b0;
        bus_read(TMR_COUNT, d);
        n_checks++;
        if (d !== 32'd0 || irq !== 1'b0) $display("FAIL rstmid_post got=%h irq=%b exp=0 irq=0", d, irq);
        else n_pass++;
        bus_read(TMR_CTRL, d);
        n_checks++;
        if (d !== 32'd0) $display("FAIL rstmid_ctrl got=%h exp=0", d);
        else n_pass++;
        idle(5);
        bus_read(TMR_COUNT, d);
        n_checks++;
        if (d !== 32'd0) $display("FAIL rstmid_hold got=%h exp=0", d);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] d;
        logic [31:0] data;
        int          r;
        int          o;
        for (int cyc = 0; cyc < 500; cyc++) begin
            r     = int'($urandom_range(0, 99));
            reset = (r < 2);
            if (r < 45) begin
                o = int'($urandom_range(0, 7));
                case (o)
                    0: data = $urandom_range(0, 7);
                    1: data = $urandom_range(0, 3);
                    2: data = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF - $urandom_range(0, 3)
                                                          : $urandom_range(0, 8);
                    3: data = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFF : $urandom_range(0, 6);
                    4: data = $urandom_range(0, 3);
                    default: data = $urandom;
                endcase
                bus.we = 1'b1;
                bus.wd = data;
                bus.a  = BASE + (32'(o) << 2) + 32'($urandom_range(0, 3));
                // Occasionally aim the store outside the window.
                if (r > 38) bus.a = $urandom & 32'h0FFF_FFFF;
            end else begin
                bus.we = 1'b0;
            end
            clk_edge();
            reset  = 1'b0;
            bus.we = 1'b0;
            for (int k = 0; k < 5; k++) begin
                bus_read(3'(k), d);
                n_checks++;
                if (d !== m_read(k)) $display("FAIL rand_rd cyc=%0d off=%0d got=%h exp=%h", cyc, k, d, m_read(k));
                else n_pass++;
            end
            n_checks++;
            if (irq !== (m_ctrl[2] & (|m_stat)))
                $display("FAIL rand_irq cyc=%0d got=%b exp=%b", cyc, irq, m_ctrl[2] & (|m_stat));
            else n_pass++;
        end
    endtask

    initial begin
        bus.we = 1'b0;
        bus.a  = 32'd0;
        bus.wd = 32'd0;
        test_reset();
        test_compare_autoreload();
        test_prescale();
        test_overflow();
        test_w1c();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
